// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, the NOP
// instruction presented on an empty fetch buffer, and the pipeline hold codes.
package ifu_fetch_pkg;

   localparam int INST_BUS_W      = 32;
   localparam int INST_ADDR_BUS_W = 32;
   localparam int HOLD_FLAG_BUS_W = 3;

   localparam logic [31:0] INST_NOP  = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Pipeline hold codes; any code at or above HOLD_PC freezes the fetch head.
   typedef enum logic [2:0] {
      HOLD_NONE = 3'd0,
      HOLD_PC   = 3'd1,
      HOLD_IF   = 3'd2,
      HOLD_ID   = 3'd3
   } hold_e;

   // Counter width able to hold the values 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous circular FIFO. Used both as the {addr, inst} prefetch
// buffer and as the address tag queue for fetches still in flight.
// A pop on an empty FIFO and a push on a full FIFO without a pop are ignored.
module ifu_fifo
   import ifu_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             pop_s;
   logic             push_s;

   // Advance a pointer, wrapping at the last entry.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(DEPTH - 1)) begin
         nxt = {PTR_W{1'b0}};
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Qualify push/pop against the current occupancy.
   always_comb begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      if (pop && (count_r != {CNT_W{1'b0}})) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      if (push && ((count_r != CNT_W'(DEPTH)) || pop_s)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
   end

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_s && !rst && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_data = mem_r[rd_ptr_r];
   assign count     = count_r;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word reads with a credit limit
// shared between in-flight fetches and buffered instructions, drops responses
// belonging to fetches made before a jump, and presents the buffer head to
// the IF/ID register.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic [2:0]        hold_flag_i,
   output logic              ibus_req_o,
   output logic [ADDR_W-1:0] ibus_addr_o,
   input  logic              ibus_gnt_i,
   input  logic              ibus_rvalid_i,
   input  logic [DATA_W-1:0] ibus_rdata_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              inst_valid_o
);

   localparam int CNT_W = cnt_width(DEPTH);

   logic [ADDR_W-1:0]        pc_r;
   logic [CNT_W-1:0]         discard_r;
   logic [ADDR_W-1:0]        last_addr_r;

   logic [CNT_W-1:0]         outstanding_s;
   logic [CNT_W-1:0]         buf_count_s;
   logic [ADDR_W-1:0]        tag_addr_s;
   logic [ADDR_W+DATA_W-1:0] buf_head_s;
   logic                     buf_valid_s;
   logic                     buf_push_s;
   logic                     pop_s;
   logic                     fire_s;
   logic                     issue_ok_s;
   logic [CNT_W:0]           credit_s;
   logic [ADDR_W-1:0]        jump_target_s;
   logic                     unused_jump_lsb_s;

   // The two low bits of a jump target carry no information for word fetch.
   assign jump_target_s     = {jump_addr_i[ADDR_W-1:2], 2'b00};
   assign unused_jump_lsb_s = ^jump_addr_i[1:0];

   // Occupancy of the prefetch buffer drives the head valid flag.
   assign buf_valid_s = (buf_count_s != {CNT_W{1'b0}});

   // Consume/issue decisions: a jump cancels both, a hold blocks the pop.
   always_comb begin
      pop_s      = 1'b0;
      credit_s   = {(CNT_W+1){1'b0}};
      issue_ok_s = 1'b0;
      fire_s     = 1'b0;
      buf_push_s = 1'b0;
      if (buf_valid_s && (hold_flag_i < HOLD_PC) && !jump_flag_i) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      // A pop this cycle frees a slot, so it can be reused immediately.
      credit_s = {1'b0, outstanding_s} + {1'b0, buf_count_s}
                 - {{CNT_W{1'b0}}, pop_s};
      if ((credit_s < (CNT_W+1)'(DEPTH)) && !jump_flag_i && !rst) begin
         issue_ok_s = 1'b1;
      end else begin
         issue_ok_s = 1'b0;
      end
      fire_s = issue_ok_s && ibus_gnt_i;
      // Responses still owed to pre-jump fetches never reach the buffer.
      if (ibus_rvalid_i && !jump_flag_i && (discard_r == {CNT_W{1'b0}})) begin
         buf_push_s = 1'b1;
      end else begin
         buf_push_s = 1'b0;
      end
   end

   // Request stays stable until granted because the credit sum only shrinks
   // while ungranted; only a jump withdraws it.
   assign ibus_req_o  = issue_ok_s;
   assign ibus_addr_o = pc_r;

   // Program counter: redirect beats sequential advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else if (jump_flag_i) begin
         pc_r <= jump_target_s;
      end else if (fire_s) begin
         pc_r <= pc_r + ADDR_W'(4);
      end
   end

   // Count of in-flight responses that must be thrown away after a jump.
   always_ff @(posedge clk) begin
      if (rst) begin
         discard_r <= {CNT_W{1'b0}};
      end else if (jump_flag_i) begin
         if (ibus_rvalid_i && (outstanding_s != {CNT_W{1'b0}})) begin
            discard_r <= outstanding_s - CNT_W'(1);
         end else begin
            discard_r <= outstanding_s;
         end
      end else if (ibus_rvalid_i && (discard_r != {CNT_W{1'b0}})) begin
         discard_r <= discard_r - CNT_W'(1);
      end
   end

   // Remember the address of the most recently consumed instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_addr_r <= {ADDR_W{1'b0}};
      end else if (pop_s) begin
         last_addr_r <= buf_head_s[ADDR_W+DATA_W-1:DATA_W];
      end
   end

   // Tag queue: address of every granted fetch, retired in response order.
   // Its occupancy is the number of outstanding fetches; a jump does not
   // flush it because the discarded responses still retire their tags.
   ifu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W)
   ) u_tag_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (fire_s),
      .push_data (pc_r),
      .pop       (ibus_rvalid_i),
      .head_data (tag_addr_s),
      .count     (outstanding_s)
   );

   // Prefetch buffer of {addr, inst}; a jump empties it.
   ifu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_prefetch_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (jump_flag_i),
      .push      (buf_push_s),
      .push_data ({tag_addr_s, ibus_rdata_i}),
      .pop       (pop_s),
      .head_data (buf_head_s),
      .count     (buf_count_s)
   );

   // Present the buffer head, or a NOP at the last delivered address.
   always_comb begin
      inst_valid_o = 1'b0;
      inst_o       = DATA_W'(INST_NOP);
      inst_addr_o  = last_addr_r;
      if (buf_valid_s) begin
         inst_valid_o = 1'b1;
         inst_o       = buf_head_s[DATA_W-1:0];
         inst_addr_o  = buf_head_s[ADDR_W+DATA_W-1:DATA_W];
      end else begin
         inst_valid_o = 1'b0;
         inst_o       = DATA_W'(INST_NOP);
         inst_addr_o  = last_addr_r;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch. A bus model answers grants in order
// after a programmable latency; a scoreboard of expected fetch addresses is
// filled on each grant and consumed when the DUT hands an instruction on.
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   localparam int DEPTH = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic [2:0]  hold_flag_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          live;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] exp_q[$];
   int          model_count;
   logic [31:0] bench_pc;
   logic [31:0] last_addr;
   int          lat;
   int          cyc;
   bit          checks_on;
   int          checks;
   int          errors;

   always #5 clk = ~clk;

   ifu_fetch #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .jump_flag_i   (jump_flag_i),
      .jump_addr_i   (jump_addr_i),
      .hold_flag_i   (hold_flag_i),
      .ibus_req_o    (ibus_req_o),
      .ibus_addr_o   (ibus_addr_o),
      .ibus_gnt_i    (ibus_gnt_i),
      .ibus_rvalid_i (ibus_rvalid_i),
      .ibus_rdata_i  (ibus_rdata_i),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o),
      .inst_valid_o  (inst_valid_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive the response, check outputs, advance the model.
   task automatic cycle();
      bit    rv;
      bit    rv_live;
      bit    pop_m;
      bit    fire;
      bit    exp_req;
      pend_t r;
      @(negedge clk);
      rv = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      ibus_rvalid_i = rv;
      ibus_rdata_i  = rv ? (pend_q[0].addr ^ DATA_KEY) : 32'hDEAD_BEEF;
      #1;
      pop_m = (model_count > 0) && (hold_flag_i < 3'd1) && !jump_flag_i;
      if (checks_on) begin
         exp_req = !rst && !jump_flag_i &&
                   ((pend_q.size() + model_count - int'(pop_m)) < DEPTH);
         check("ibus_req", 64'(ibus_req_o), 64'(exp_req));
         if (exp_req) check("ibus_addr", 64'(ibus_addr_o), 64'(bench_pc));
         check("inst_valid", 64'(inst_valid_o), 64'(model_count > 0));
         if (model_count > 0) begin
            check("inst_addr", 64'(inst_addr_o), 64'(exp_q[0]));
            check("inst_data", 64'(inst_o), 64'(exp_q[0] ^ DATA_KEY));
         end else begin
            check("inst_addr_idle", 64'(inst_addr_o), 64'(last_addr));
            check("inst_nop", 64'(inst_o), 64'(INST_NOP));
         end
      end
      fire    = ibus_req_o && ibus_gnt_i;
      rv_live = 1'b0;
      if (rv) begin
         r       = pend_q.pop_front();
         rv_live = r.live;
      end
      if (rst) begin
         exp_q.delete();
         model_count = 0;
         bench_pc    = RESET_PC;
         last_addr   = 32'h0000_0000;
         foreach (pend_q[i]) pend_q[i].live = 1'b0;
         checks_on   = 1'b1;
      end else if (jump_flag_i) begin
         exp_q.delete();
         model_count = 0;
         bench_pc    = {jump_addr_i[31:2], 2'b00};
         foreach (pend_q[i]) pend_q[i].live = 1'b0;
      end else begin
         if (rv_live) begin
            model_count++;
            if (!pop_m) check("buf_overflow", 64'(model_count <= DEPTH), 64'd1);
         end
         if (pop_m) begin
            last_addr = exp_q.pop_front();
            model_count--;
         end
         if (fire) begin
            pend_q.push_back('{addr: bench_pc, due: cyc + lat, live: 1'b1});
            exp_q.push_back(bench_pc);
            bench_pc = bench_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cycle();
      rst = 1'b0;
      pend_q.delete();
   endtask

   initial begin
      int n;
      checks = 0; errors = 0; cyc = 0; checks_on = 1'b0;
      model_count = 0; bench_pc = RESET_PC; last_addr = 32'h0000_0000;
      rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = 32'h0000_0000;
      hold_flag_i = HOLD_NONE; ibus_gnt_i = 1'b1; ibus_rvalid_i = 1'b0;
      ibus_rdata_i = 32'h0000_0000; lat = 1;

      // Reset, free run, then grant held low at address 0x8.
      do_reset(3);
      repeat (2) cycle();
      ibus_gnt_i = 1'b0;
      repeat (3) cycle();
      ibus_gnt_i = 1'b1;
      repeat (8) cycle();

      // Hold_If for five cycles with 0x10 at the head.
      do_reset(2);
      n = 0;
      while (!(model_count > 0 && exp_q[0] == 32'h10) && n < 40) begin
         cycle(); n++;
      end
      check("reach_head_10", 64'(n < 40), 64'd1);
      hold_flag_i = HOLD_IF;
      repeat (5) cycle();
      hold_flag_i = HOLD_NONE;
      repeat (4) cycle();

      // Jump to 0x100 with two fetches in flight at 3-cycle latency.
      lat = 3;
      n = 0;
      while (pend_q.size() != 2 && n < 40) begin
         cycle(); n++;
      end
      check("two_in_flight", 64'(n < 40), 64'd1);
      jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
      cycle();
      jump_flag_i = 1'b0;
      repeat (12) cycle();

      // Jump to 0x203 in the cycle that 0x40 returns.
      lat = 1;
      do_reset(2);
      n = 0;
      while (!(pend_q.size() > 0 && pend_q[0].addr == 32'h40 && pend_q[0].due <= cyc) && n < 60) begin
         cycle(); n++;
      end
      check("reach_rvalid_40", 64'(n < 60), 64'd1);
      jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0203;
      cycle();
      jump_flag_i = 1'b0;
      repeat (8) cycle();

      // Reset mid-stream with one buffered and one in flight; the late
      // response lands during reset.
      do_reset(2);
      lat = 3;
      hold_flag_i = HOLD_ID;
      n = 0;
      while (!(model_count == 1 && pend_q.size() == 1) && n < 40) begin
         cycle(); n++;
      end
      check("reach_mid_stream", 64'(n < 40), 64'd1);
      do_reset(4);
      hold_flag_i = HOLD_NONE;
      lat = 1;
      repeat (10) cycle();

      // Stop granting and let every expected instruction drain out.
      ibus_gnt_i = 1'b0;
      n = 0;
      while ((pend_q.size() != 0 || model_count != 0) && n < 20) begin
         cycle(); n++;
      end
      check("drain", 64'(n < 20), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
